// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, GF(2^8) helpers and InvShiftRows wiring for the decrypt diffusion path.
package aes_pkg;
  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {IDLE, MIX, DONE} diff_state_e;
  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam logic [7:0] IMC_0E = 8'h0e;
  localparam logic [7:0] IMC_0B = 8'h0b;
  localparam logic [7:0] IMC_0D = 8'h0d;
  localparam logic [7:0] IMC_09 = 8'h09;
  function automatic int byte_msb(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction
  // Shift-and-add over GF(2^8); with a constant operand this folds to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] k, input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (k[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[byte_msb(r, c) -: 8] = s[byte_msb(r, (c + 4 - r) % 4) -: 8];
    return o;
  endfunction
endpackage

// File: rtl/inv_mix_column.sv
// inv_mix_column: combinational InvMixColumns on one 32-bit column (row 0 in the top byte).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);
  logic [7:0] w_a [4];
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_a[r] = i_col[31-8*r -: 8];
    assign o_col[31-8*r -: 8] = gf_mul(IMC_0E, w_a[r]) ^ gf_mul(IMC_0B, w_a[(r+1)%4]) ^
                                gf_mul(IMC_0D, w_a[(r+2)%4]) ^ gf_mul(IMC_09, w_a[(r+3)%4]);
  end
endmodule

// File: rtl/inv_diffusion.sv
// inv_diffusion: out = InvShiftRows(InvMixColumns(in)), column-serial with valid/ready on both sides.
// Optional INV_DIFF_SKIP_MIX_EN adds skip_mix to bypass InvMixColumns for the first decrypt round.
module inv_diffusion
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef INV_DIFF_SKIP_MIX_EN
  input  logic         skip_mix,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  diff_state_e r_state, w_state_next;
  state_t      r_data, w_mix_data;
  logic [1:0]  r_col_cnt;
  logic [1:0]  w_idx [COLS_PER_CYCLE];
  logic [31:0] w_mix_in [COLS_PER_CYCLE];
  logic [31:0] w_mix_out [COLS_PER_CYCLE];
  logic [31:0] w_cols [4];
  logic [31:0] w_cols_next [4];
  logic        w_skip, w_accept, w_last;
`ifdef INV_DIFF_SKIP_MIX_EN
  assign w_skip = skip_mix;
`else
  assign w_skip = 1'b0;
`endif
  for (genvar k = 0; k < 4; k++) begin : g_col
    assign w_cols[k] = r_data[127-32*k -: 32];
    assign w_mix_data[127-32*k -: 32] = w_cols_next[k];
  end
  for (genvar c = 0; c < COLS_PER_CYCLE; c++) begin : g_mix
    assign w_idx[c] = r_col_cnt + 2'(c);
    assign w_mix_in[c] = w_cols[w_idx[c]];
    inv_mix_column u_imc (.i_col(w_mix_in[c]), .o_col(w_mix_out[c]));
  end
  always_comb begin
    w_cols_next = w_cols;
    for (int c = 0; c < COLS_PER_CYCLE; c++) w_cols_next[w_idx[c]] = w_mix_out[c];
  end
  assign w_last    = w_idx[COLS_PER_CYCLE-1] == 2'd3;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_accept  = in_valid & in_ready;
  assign out_data  = inv_shift_rows(r_data);
  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE && in_valid) w_state_next = w_skip ? DONE : MIX;
    if (r_state == MIX && w_last) w_state_next = DONE;
    if (r_state == DONE && out_ready) w_state_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_col_cnt <= '0;
    end else if (w_accept) begin
      r_data    <= in_data;
      r_col_cnt <= '0;
    end else if (r_state == MIX) begin
      r_data    <= w_mix_data;
      r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
    end
  end
endmodule

// File: tb/tb_inv_diffusion.sv
// tb_inv_diffusion: randomized and directed checks of inv_diffusion against a GF(2^8) reference model.
module tb_inv_diffusion;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, skip_mix = 0;
  logic [127:0] in_data = '0;
  logic in_ready, out_valid;
  logic [127:0] out_data;
  logic m_valid = 0, m_ready = 1;
  logic [127:0] m_data = '0;
  logic r2, v2, r4, v4;
  logic [127:0] d2, d4;
  int checks = 0, errors = 0;
  localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SKIP_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  inv_diffusion #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst),
`ifdef INV_DIFF_SKIP_MIX_EN
    .skip_mix(skip_mix),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
  inv_diffusion #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst),
`ifdef INV_DIFF_SKIP_MIX_EN
    .skip_mix(1'b0),
`endif
    .in_valid(m_valid), .in_ready(r2), .in_data(m_data),
    .out_valid(v2), .out_ready(m_ready), .out_data(d2));
  inv_diffusion #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst),
`ifdef INV_DIFF_SKIP_MIX_EN
    .skip_mix(1'b0),
`endif
    .in_valid(m_valid), .in_ready(r4), .in_data(m_data),
    .out_valid(v4), .out_ready(m_ready), .out_data(d4));

  // Polynomial product followed by long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction
  function automatic logic [127:0] model_imc(input logic [127:0] s);
    logic [7:0] a [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) a[r][c] = s[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++)
      o[127-8*(4*c+r) -: 8] = gmul(8'h0e, a[r][c]) ^ gmul(8'h0b, a[(r+1)%4][c]) ^
                              gmul(8'h0d, a[(r+2)%4][c]) ^ gmul(8'h09, a[(r+3)%4][c]);
    return o;
  endfunction
  function automatic logic [127:0] model_isr(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++)
      o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] s);
    return model_isr(model_imc(s));
  endfunction
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one block into u1; lat counts edges from the accepting edge (inclusive) to out_valid.
  task automatic run_block(input logic [127:0] d, output logic [127:0] q, output int lat);
    int w;
    in_data = d;
    in_valid = 1;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    q = out_data;
    if (out_ready && out_valid) tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 128'h0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b data=%h exp 1 0 0", in_ready, out_valid, out_data);
    end
    checks++;
    if ({r2, v2, d2, r4, v4, d4} !== {1'b1, 1'b0, 128'h0, 1'b1, 1'b0, 128'h0}) begin
      errors++;
      $display("FAIL reset_state_wide got r2=%b v2=%b r4=%b v4=%b", r2, v2, r4, v4);
    end
    in_data = rand128();
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
    if ({in_ready, out_data} !== {1'b1, 128'h0}) begin
      errors++;
      $display("FAIL reset_wins got rdy=%b data=%h exp 1 0", in_ready, out_data);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_single_column();
    logic [31:0] cin [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h01010101};
    logic [31:0] cex [4] = '{32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h01010101};
    logic [127:0] q, e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_block({cin[i], 96'h0}, q, lat);
      e = model_isr({cex[i], 96'h0});
      checks++;
      if (q !== e) begin
        errors++;
        $display("FAIL single_col%0d got %h exp %h", i, q, e);
      end
    end
  endtask

  task automatic test_full_block();
    logic [127:0] q, q2, q4;
    int lat, l2, l4;
    run_block(FIPS_IN, q, lat);
    checks++;
    if (q !== FIPS_OUT) begin errors++; $display("FAIL fips_c1 got %h exp %h", q, FIPS_OUT); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL latency_c1 got %0d exp 5", lat); end
    checks++;
    if (model(FIPS_IN) !== FIPS_OUT) begin errors++; $display("FAIL model_fips got %h exp %h", model(FIPS_IN), FIPS_OUT); end
    m_data = FIPS_IN;
    m_valid = 1;
    tick();
    m_valid = 0;
    l2 = 0; l4 = 0; q2 = '0; q4 = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (l2 == 0 && v2) begin l2 = cyc; q2 = d2; end
      if (l4 == 0 && v4) begin l4 = cyc; q4 = d4; end
      tick();
    end
    checks++;
    if (q2 !== FIPS_OUT || l2 != 3) begin errors++; $display("FAIL fips_c2 got %h lat %0d exp %h lat 3", q2, l2, FIPS_OUT); end
    checks++;
    if (q4 !== FIPS_OUT || l4 != 2) begin errors++; $display("FAIL fips_c4 got %h lat %0d exp %h lat 2", q4, l4, FIPS_OUT); end
  endtask

  task automatic test_random();
    logic [127:0] d, q;
    int lat;
    for (int i = 0; i < 10; i++) begin
      d = rand128();
      run_block(d, q, lat);
      checks++;
      if (q !== model(d) || lat != 5) begin
        errors++;
        $display("FAIL random%0d in %h got %h lat %0d exp %h lat 5", i, d, q, lat, model(d));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, q;
    int lat;
    logic bad;
    d = rand128();
    out_ready = 0;
    run_block(d, q, lat);
    checks++;
    if (q !== model(d)) begin errors++; $display("FAIL bp_data got %h exp %h", q, model(d)); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== q || in_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_stable got vld=%b rdy=%b data=%h exp 1 0 %h", out_valid, in_ready, out_data, q); end
    out_ready = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [3];
    logic [127:0] od;
    logic acc, oh;
    int idx, nout, cyc, last_acc;
    for (int i = 0; i < 3; i++) blk[i] = rand128();
    out_ready = 1;
    idx = 0; nout = 0; cyc = 0; last_acc = 0;
    in_data = blk[0];
    in_valid = 1;
    while (nout < 3 && cyc < 100) begin
      acc = in_valid && in_ready;
      oh = out_valid && out_ready;
      od = out_data;
      tick();
      cyc++;
      if (acc) begin
        if (idx > 0) begin
          checks++;
          if (cyc - last_acc != 6) begin errors++; $display("FAIL b2b_interval%0d got %0d exp 6", idx, cyc - last_acc); end
        end
        last_acc = cyc;
        idx++;
        if (idx < 3) in_data = blk[idx];
        else in_valid = 0;
      end
      if (oh) begin
        checks++;
        if (od !== model(blk[nout])) begin errors++; $display("FAIL b2b_out%0d got %h exp %h", nout, od, model(blk[nout])); end
        nout++;
      end
    end
    in_valid = 0;
    checks++;
    if (nout != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", nout); end
  endtask

  task automatic test_reset_in_mix();
    logic [127:0] q;
    int lat;
    in_data = rand128();
    in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 128'h0}) begin
      errors++;
      $display("FAIL mix_reset got rdy=%b vld=%b data=%h exp 1 0 0", in_ready, out_valid, out_data);
    end
    run_block(FIPS_IN, q, lat);
    checks++;
    if (q !== FIPS_OUT) begin errors++; $display("FAIL after_reset got %h exp %h", q, FIPS_OUT); end
  endtask

`ifdef INV_DIFF_SKIP_MIX_EN
  task automatic test_skip_mix();
    logic [127:0] q;
    int lat;
    skip_mix = 1;
    run_block(SKIP_IN, q, lat);
    skip_mix = 0;
    checks++;
    if (q !== FIPS_OUT || lat != 1) begin errors++; $display("FAIL skip_mix got %h lat %0d exp %h lat 1", q, lat, FIPS_OUT); end
    run_block(FIPS_IN, q, lat);
    checks++;
    if (q !== FIPS_OUT || lat != 5) begin errors++; $display("FAIL skip_off got %h lat %0d exp %h lat 5", q, lat, FIPS_OUT); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_column();
    test_full_block();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_in_mix();
`ifdef INV_DIFF_SKIP_MIX_EN
    test_skip_mix();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
